// File: rtl/hazard_pkg.sv
// Shared types and helpers for the operand forwarding / hazard unit.
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RF,
    FWD_STG,
    FWD_LC
  } fwd_sel_e;

  localparam int unsigned STALL_CNT_W = 16;

  // Low bit of element idx inside a flat vector of width-sized elements.
  function automatic int unsigned slice_lo(input int unsigned idx, input int unsigned width);
    return idx * width;
  endfunction

endpackage

// File: rtl/fwd_port_mux.sv
// Operand resolution for one read port: pipeline bypass, long-op completion bypass or RF data.
module fwd_port_mux
  import hazard_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned RAW  = 5,
  parameter int unsigned NFS  = 2
) (
  input  logic                  use_r,
  input  logic [RAW-1:0]        rs,
  input  logic [XLEN-1:0]       rf_data,
  input  logic [NFS-1:0]        st_rw,
  input  logic [NFS*RAW-1:0]    st_rd,
  input  logic [NFS-1:0]        st_ok,
  input  logic [NFS*XLEN-1:0]   st_data,
  input  logic [(1<<RAW)-1:0]   busy,
  input  logic                  lc_valid,
  input  logic [RAW-1:0]        lc_rd,
  input  logic [XLEN-1:0]       lc_data,
  output logic [XLEN-1:0]       data,
  output logic                  need_stall
);

  fwd_sel_e    sel;
  logic        hit;
  int unsigned hit_idx;

  // Youngest matching stage; stage 0 is searched first so it shadows older ones.
  always_comb begin
    hit     = 1'b0;
    hit_idx = 0;
    for (int unsigned k = 0; k < NFS; k++) begin
      if (!hit && st_rw[k] && (st_rd[slice_lo(k, RAW) +: RAW] == rs)) begin
        hit     = 1'b1;
        hit_idx = k;
      end
    end
  end

  // An unresolved younger match stalls even when an older stage holds a valid value.
  always_comb begin
    sel        = FWD_RF;
    need_stall = 1'b0;
    if (use_r && (rs != '0)) begin
      if (hit) begin
        if (st_ok[hit_idx]) sel = FWD_STG;
        else                need_stall = 1'b1;
      end else if (busy[rs]) begin
        if (lc_valid && (lc_rd == rs)) sel = FWD_LC;
        else                           need_stall = 1'b1;
      end
    end
  end

  always_comb begin
    data = rf_data;
    case (sel)
      FWD_STG: data = st_data[slice_lo(hit_idx, XLEN) +: XLEN];
      FWD_LC:  data = lc_data;
      default: data = rf_data;
    endcase
  end

endmodule

// File: rtl/hazard_fwd_scoreboard.sv
// Forwarding + hazard unit: per-port bypass muxes, long-op register scoreboard,
// RAW/WAW stall generation, stall statistics and a stall watchdog.
module hazard_fwd_scoreboard
  import hazard_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned RAW     = 5,
  parameter int unsigned NRP     = 3,
  parameter int unsigned NFS     = 2,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NRP-1:0]          use_r,
  input  logic [NRP*RAW-1:0]      rs,
  input  logic [NRP*XLEN-1:0]     rf_data,
  input  logic [NFS-1:0]          st_rw,
  input  logic [NFS*RAW-1:0]      st_rd,
  input  logic [NFS-1:0]          st_ok,
  input  logic [NFS*XLEN-1:0]     st_data,
  input  logic                    issue_valid,
  input  logic [RAW-1:0]          issue_rd,
  input  logic                    issue_long,
  input  logic                    lc_valid,
  input  logic [RAW-1:0]          lc_rd,
  input  logic [XLEN-1:0]         lc_data,
  output logic [NRP*XLEN-1:0]     fwd_data,
  output logic                    stall,
  output logic                    issue_fire,
  output logic [STALL_CNT_W-1:0]  stall_cnt,
  output logic                    hazard_timeout
);

  localparam int unsigned NREG  = 1 << RAW;
  localparam int unsigned RUN_W = $clog2(TIMEOUT + 1);

  logic [NREG-1:0]  busy;
  logic [NREG-1:0]  busy_nxt;
  logic [NRP-1:0]   port_stall;
  logic             waw;
  logic [RUN_W-1:0] run_cnt;

  for (genvar i = 0; i < NRP; i++) begin : g_port
    fwd_port_mux #(
      .XLEN (XLEN),
      .RAW  (RAW),
      .NFS  (NFS)
    ) u_mux (
      .use_r      (use_r[i]),
      .rs         (rs[slice_lo(i, RAW) +: RAW]),
      .rf_data    (rf_data[slice_lo(i, XLEN) +: XLEN]),
      .st_rw      (st_rw),
      .st_rd      (st_rd),
      .st_ok      (st_ok),
      .st_data    (st_data),
      .busy       (busy),
      .lc_valid   (lc_valid),
      .lc_rd      (lc_rd),
      .lc_data    (lc_data),
      .data       (fwd_data[slice_lo(i, XLEN) +: XLEN]),
      .need_stall (port_stall[i])
    );
  end

  // A completing long op releases its destination in time for a same-cycle rewrite.
  assign waw = (issue_rd != '0) && busy[issue_rd] && !(lc_valid && (lc_rd == issue_rd));

  assign stall      = issue_valid && ((|port_stall) || waw);
  assign issue_fire = issue_valid && !stall;

  // Clear first so a same-cycle set of the same index wins.
  always_comb begin
    busy_nxt = busy;
    if (lc_valid) busy_nxt[lc_rd] = 1'b0;
    if (issue_fire && issue_long && (issue_rd != '0)) busy_nxt[issue_rd] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy           <= '0;
      stall_cnt      <= '0;
      run_cnt        <= '0;
      hazard_timeout <= 1'b0;
    end else begin
      busy <= busy_nxt;
      if (stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + STALL_CNT_W'(1);
      if (!stall)                              run_cnt <= '0;
      else if (run_cnt != RUN_W'(TIMEOUT))     run_cnt <= run_cnt + RUN_W'(1);
      if (stall && (run_cnt == RUN_W'(TIMEOUT - 1))) hazard_timeout <= 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_fwd_scoreboard.sv
// Directed self-checking bench for hazard_fwd_scoreboard.
module tb_hazard_fwd_scoreboard;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned RAW     = 5;
  localparam int unsigned NRP     = 3;
  localparam int unsigned NFS     = 2;
  localparam int unsigned TIMEOUT = 1024;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NRP-1:0]       use_r;
  logic [NRP*RAW-1:0]   rs;
  logic [NRP*XLEN-1:0]  rf_data;
  logic [NFS-1:0]       st_rw;
  logic [NFS*RAW-1:0]   st_rd;
  logic [NFS-1:0]       st_ok;
  logic [NFS*XLEN-1:0]  st_data;
  logic                 issue_valid;
  logic [RAW-1:0]       issue_rd;
  logic                 issue_long;
  logic                 lc_valid;
  logic [RAW-1:0]       lc_rd;
  logic [XLEN-1:0]      lc_data;
  logic [NRP*XLEN-1:0]  fwd_data;
  logic                 stall;
  logic                 issue_fire;
  logic [15:0]          stall_cnt;
  logic                 hazard_timeout;

  int n_assert = 0;
  int n_fail   = 0;

  hazard_fwd_scoreboard #(
    .XLEN(XLEN), .RAW(RAW), .NRP(NRP), .NFS(NFS), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .use_r(use_r), .rs(rs), .rf_data(rf_data),
    .st_rw(st_rw), .st_rd(st_rd), .st_ok(st_ok), .st_data(st_data),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_long(issue_long),
    .lc_valid(lc_valid), .lc_rd(lc_rd), .lc_data(lc_data),
    .fwd_data(fwd_data), .stall(stall), .issue_fire(issue_fire),
    .stall_cnt(stall_cnt), .hazard_timeout(hazard_timeout)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rfv(input int unsigned i);
    return 32'hF000_0000 | 32'(i);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after a rising edge; checks happen 2 units later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic idle();
    use_r = '0; rs = '0;
    st_rw = '0; st_rd = '0; st_ok = '0; st_data = '0;
    issue_valid = 1'b0; issue_rd = '0; issue_long = 1'b0;
    lc_valid = 1'b0; lc_rd = '0; lc_data = '0;
  endtask

  task automatic set_rs(input int unsigned p, input logic [RAW-1:0] r);
    rs[p*RAW +: RAW] = r;
  endtask

  task automatic set_st(input int unsigned k, input logic rw, input logic [RAW-1:0] rd,
                        input logic ok, input logic [XLEN-1:0] d);
    st_rw[k] = rw;
    st_rd[k*RAW +: RAW] = rd;
    st_ok[k] = ok;
    st_data[k*XLEN +: XLEN] = d;
  endtask

  function automatic logic [31:0] fwd(input int unsigned p);
    return fwd_data[p*XLEN +: XLEN];
  endfunction

  initial begin
    idle();
    for (int i = 0; i < int'(NRP); i++) rf_data[i*XLEN +: XLEN] = rfv(i);
    rst = 1'b1;
    #1;
    tick();
    tick();
    rst = 1'b0;
    settle();
    chk("reset_stall_cnt", 32'(stall_cnt), 32'd0);
    chk("reset_timeout", 32'(hazard_timeout), 32'd0);
    chk("reset_stall", 32'(stall), 32'd0);
    chk("reset_fwd0", fwd(0), rfv(0));

    // 1: youngest stage shadows older one
    use_r = 3'b001; set_rs(0, 5);
    set_st(0, 1'b1, 5, 1'b1, 32'hAA);
    set_st(1, 1'b1, 5, 1'b1, 32'hBB);
    issue_valid = 1'b1; issue_rd = 5'd1;
    settle();
    chk("t1_fwd0_young", fwd(0), 32'hAA);
    chk("t1_stall", 32'(stall), 32'd0);
    chk("t1_fire", 32'(issue_fire), 32'd1);
    chk("t1_fwd1_unused", fwd(1), rfv(1));
    st_rw[0] = 1'b0;
    settle();
    chk("t1_fwd0_old", fwd(0), 32'hBB);
    tick();

    // 2: younger load not resolved stalls despite valid older stage
    idle();
    use_r = 3'b001; set_rs(0, 7);
    set_st(0, 1'b1, 7, 1'b0, 32'h70);
    set_st(1, 1'b1, 7, 1'b1, 32'h71);
    settle();
    chk("t2_stall_noissue", 32'(stall), 32'd0);
    issue_valid = 1'b1; issue_rd = 5'd2;
    settle();
    chk("t2_stall", 32'(stall), 32'd1);
    chk("t2_fire", 32'(issue_fire), 32'd0);
    tick();
    st_ok = 2'b11;
    settle();
    chk("t2_stall_resolved", 32'(stall), 32'd0);
    chk("t2_fwd0", fwd(0), 32'h70);
    chk("t2_stall_cnt", 32'(stall_cnt), 32'd1);
    tick();

    // 3: long op RAW, released by completion bypass
    idle();
    issue_valid = 1'b1; issue_long = 1'b1; issue_rd = 5'd9;
    settle();
    chk("t3_issue_fire", 32'(issue_fire), 32'd1);
    tick();
    issue_long = 1'b0; issue_rd = 5'd3;
    use_r = 3'b010; set_rs(1, 9);
    settle();
    chk("t3_raw_stall_a", 32'(stall), 32'd1);
    tick();
    settle();
    chk("t3_raw_stall_b", 32'(stall), 32'd1);
    tick();
    lc_valid = 1'b1; lc_rd = 5'd9; lc_data = 32'h1234;
    settle();
    chk("t3_lc_fwd1", fwd(1), 32'h1234);
    chk("t3_lc_stall", 32'(stall), 32'd0);
    tick();
    lc_valid = 1'b0; lc_data = '0;
    settle();
    chk("t3_cleared_stall", 32'(stall), 32'd0);
    chk("t3_cleared_fwd1", fwd(1), rfv(1));
    chk("t3_stall_cnt", 32'(stall_cnt), 32'd3);
    tick();

    // 4: WAW and same-cycle set/clear
    idle();
    issue_valid = 1'b1; issue_long = 1'b1; issue_rd = 5'd9;
    tick();
    issue_long = 1'b0;
    settle();
    chk("t4_waw_stall", 32'(stall), 32'd1);
    issue_long = 1'b1; lc_valid = 1'b1; lc_rd = 5'd9; lc_data = 32'h55;
    settle();
    chk("t4_setclr_stall", 32'(stall), 32'd0);
    chk("t4_setclr_fire", 32'(issue_fire), 32'd1);
    tick();
    idle();
    issue_valid = 1'b1; issue_rd = 5'd2;
    use_r = 3'b010; set_rs(1, 9);
    settle();
    chk("t4_still_busy", 32'(stall), 32'd1);
    issue_valid = 1'b0; lc_valid = 1'b1; lc_rd = 5'd9;
    tick();
    lc_valid = 1'b0; issue_valid = 1'b1;
    settle();
    chk("t4_released", 32'(stall), 32'd0);
    chk("t4_stall_cnt", 32'(stall_cnt), 32'd3);
    tick();

    // 5: x0 never forwarded or scoreboarded; completion to idle reg ignored
    idle();
    use_r = 3'b001; set_rs(0, 0);
    set_st(0, 1'b1, 0, 1'b0, 32'hDEAD);
    issue_valid = 1'b1; issue_long = 1'b1; issue_rd = 5'd0;
    lc_valid = 1'b1; lc_rd = 5'd4; lc_data = 32'h44;
    settle();
    chk("t5_x0_fwd0", fwd(0), rfv(0));
    chk("t5_x0_stall", 32'(stall), 32'd0);
    tick();
    idle();
    use_r = 3'b111; set_rs(0, 4); set_rs(1, 0); set_rs(2, 6);
    set_st(1, 1'b1, 6, 1'b1, 32'h66);
    issue_valid = 1'b1; issue_long = 1'b0; issue_rd = 5'd0;
    settle();
    chk("t5_x0_no_waw", 32'(stall), 32'd0);
    chk("t5_fwd0_rf", fwd(0), rfv(0));
    chk("t5_fwd2_stage1", fwd(2), 32'h66);
    tick();

    // 6: watchdog after TIMEOUT consecutive stall cycles
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    issue_valid = 1'b1; issue_long = 1'b1; issue_rd = 5'd12;
    tick();
    issue_long = 1'b0; issue_rd = 5'd1;
    use_r = 3'b001; set_rs(0, 12);
    settle();
    chk("t6_stall", 32'(stall), 32'd1);
    for (int i = 1; i < int'(TIMEOUT); i++) tick();
    settle();
    chk("t6_timeout_pre", 32'(hazard_timeout), 32'd0);
    chk("t6_stall_cnt_pre", 32'(stall_cnt), 32'(TIMEOUT - 1));
    tick();
    settle();
    chk("t6_timeout", 32'(hazard_timeout), 32'd1);
    chk("t6_stall_cnt", 32'(stall_cnt), 32'(TIMEOUT));
    issue_valid = 1'b0;
    tick();
    settle();
    chk("t6_timeout_sticky", 32'(hazard_timeout), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    issue_valid = 1'b1;
    settle();
    chk("t6_rst_timeout", 32'(hazard_timeout), 32'd0);
    chk("t6_rst_stall_cnt", 32'(stall_cnt), 32'd0);
    chk("t6_rst_busy", 32'(stall), 32'd0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
